creator_clk_div_gen: RTL and testbench

- Programmable clock divider and strobe generator fed by the 200 MHz system clock from the board DCM (clk_out_200 used as clk).
- Produces a glitch-free registered divided clock (div_clk), for example the microphone PDM clock.
- Also produces a one-cycle rise strobe and a decimated sample strobe in the 200 MHz domain for downstream capture and filter logic.
- The divisor is reloadable at run time; a reload takes effect only at a period boundary.

---
 rtl/creator_clk_div_gen.sv | 130 +++++++++++++
 tb/tb_creator_clk_div_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/creator_clk_div_gen.sv
// Programmable 50%-duty clock divider with one-cycle rise strobe and decimated sample strobe.
// Divisor reloads are deferred to the rising edge of div_clk so that every full period uses a single half-period.
module creator_clk_div_gen #(
    parameter int DIV_W     = 8,
    parameter int DEC_W     = 8,
    parameter int DECIM     = 64,
    parameter int RESET_DIV = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_value,
    input  logic             div_load,
    output logic             div_clk,
    output logic             rise_stb,
    output logic             sample_stb,
    output logic             running,
    output logic [DIV_W-1:0] cur_div
);

    typedef enum logic [1:0] { IDLE, RUN, STOP } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] cur_div_n;
    logic [DIV_W-1:0] pend, pend_n;
    logic             pend_valid, pend_valid_n;
    logic [DEC_W-1:0] dec_cnt, dec_cnt_n;
    logic             div_clk_n, rise_n, sample_n;
    logic             wrap, apply;

    // A divisor of 0 is stored as 1, so cur_div always holds the effective half-period.
    function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

    assign wrap    = (cnt == cur_div - DIV_W'(1));
    assign running = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        div_clk_n    = div_clk;
        cur_div_n    = cur_div;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        dec_cnt_n    = dec_cnt;
        rise_n       = 1'b0;
        sample_n     = 1'b0;
        apply        = 1'b0;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                div_clk_n = 1'b0;
                dec_cnt_n = '0;
                apply     = pend_valid;
                if (enable) state_n = RUN;
            end
            RUN, STOP: begin
                if (state == STOP && !enable && !div_clk) begin
                    // Already low: leaving now cannot truncate a high pulse.
                    state_n   = IDLE;
                    cnt_n     = '0;
                    dec_cnt_n = '0;
                end else begin
                    state_n = enable ? RUN : STOP;
                    if (wrap) begin
                        cnt_n     = '0;
                        div_clk_n = !div_clk;
                        if (!div_clk) begin
                            rise_n = 1'b1;
                            apply  = pend_valid;
                            if (dec_cnt == DEC_W'(DECIM - 1)) begin
                                sample_n  = 1'b1;
                                dec_cnt_n = '0;
                            end else begin
                                dec_cnt_n = dec_cnt + DEC_W'(1);
                            end
                        end else if (state == STOP && !enable) begin
                            state_n   = IDLE;
                            dec_cnt_n = '0;
                        end
                    end else begin
                        cnt_n = cnt + DIV_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A load coinciding with an apply keeps the new value pending for the next period.
        if (apply) begin
            cur_div_n    = clamp(pend);
            pend_valid_n = 1'b0;
        end
        if (div_load) begin
            pend_n       = div_value;
            pend_valid_n = 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // NOTE: every register, including cur_div and pend, takes its value from the asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            div_clk    <= 1'b0;
            cur_div    <= DIV_W'(RESET_DIV);
            pend       <= '0;
            pend_valid <= 1'b0;
            dec_cnt    <= '0;
            rise_stb   <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            div_clk    <= div_clk_n;
            cur_div    <= cur_div_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            dec_cnt    <= dec_cnt_n;
            rise_stb   <= rise_n;
            sample_stb <= sample_n;
        end
    end

endmodule

// File: tb/tb_creator_clk_div_gen.sv
// Self-checking bench for creator_clk_div_gen: directed scenarios plus randomized traffic
// compared against a countdown-based reference model of the divider.
module tb_creator_clk_div_gen;

    localparam int DIV_W     = 8;
    localparam int DEC_W     = 8;
    localparam int DECIM     = 64;
    localparam int RESET_DIV = 32;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    logic             clk       = 1'b0;
    logic             resetn    = 1'b0;
    logic             enable    = 1'b0;
    logic             div_load  = 1'b0;
    logic [DIV_W-1:0] div_value = '0;
    logic             div_clk, rise_stb, sample_stb, running;
    logic [DIV_W-1:0] cur_div;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    creator_clk_div_gen #(
        .DIV_W(DIV_W), .DEC_W(DEC_W), .DECIM(DECIM), .RESET_DIV(RESET_DIV)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .div_value(div_value),
        .div_load(div_load), .div_clk(div_clk), .rise_stb(rise_stb),
        .sample_stb(sample_stb), .running(running), .cur_div(cur_div)
    );

    // Reference model: counts down the cycles left in the current half-period.
    typedef struct packed {
        int mode;
        bit level;
        int left;
        int h;
        int pend;
        bit pv;
        int rises;
        bit rise;
        bit sample;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t n;
        n.mode = M_IDLE; n.level = 0; n.left = 0; n.h = RESET_DIV; n.pend = 0;
        n.pv = 0; n.rises = 0; n.rise = 0; n.sample = 0;
        return n;
    endfunction

    function automatic model_t model_step(model_t s, bit en, bit ld, int val);
        model_t n;
        bit apply, reload;
        n = s; apply = 0; reload = 0; n.rise = 0; n.sample = 0;
        if (s.mode == M_IDLE) begin
            n.level = 0; n.rises = 0; apply = s.pv; reload = 1;
            if (en) n.mode = M_RUN;
        end else if (s.mode == M_STOP && !en && !s.level) begin
            n.mode = M_IDLE; n.rises = 0;
        end else begin
            n.mode = en ? M_RUN : M_STOP;
            n.left = s.left - 1;
            if (n.left == 0) begin
                n.level = !s.level; reload = 1;
                if (n.level) begin
                    n.rise = 1; n.rises = s.rises + 1; apply = s.pv;
                    if (n.rises == DECIM) begin n.sample = 1; n.rises = 0; end
                end else if (s.mode == M_STOP && !en) begin
                    n.mode = M_IDLE; n.rises = 0;
                end
            end
        end
        if (apply) begin n.h = (s.pend == 0) ? 1 : s.pend; n.pv = 0; end
        if (ld) begin n.pend = val; n.pv = 1; end
        if (reload) n.left = n.h;
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= model_reset();
        else         m <= model_step(m, enable, div_load, int'(div_value));
    end

    // Waits for the next rise_stb (sampled on falling edges); cycles = -1 on timeout.
    task automatic wait_rise(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (rise_stb !== 1'b1 && cycles < limit);
        if (rise_stb !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; div_load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({div_clk, rise_stb, sample_stb, running, cur_div} !== {4'b0000, DIV_W'(RESET_DIV)}) begin
            failures++;
            $display("FAIL reset_outputs: got clk/rise/sample/run=%b%b%b%b cur_div=%0d expected 0000 cur_div=%0d",
                     div_clk, rise_stb, sample_stb, running, cur_div, RESET_DIV);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({div_clk, running} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: got div_clk=%b running=%b expected 0 0", div_clk, running);
        end
    endtask

    task automatic test_default_run();
        int c, cyc, rises;
        enable = 1'b1;
        c = 0;
        do begin @(negedge clk); c++; end while (div_clk !== 1'b1 && c < 200);
        // One edge to enter RUN, then H more edges to the first rise.
        checks++;
        if (c != RESET_DIV + 1) begin
            failures++; $display("FAIL first_rise_delay: got %0d expected %0d", c, RESET_DIV + 1);
        end
        checks++;
        if (rise_stb !== 1'b1) begin
            failures++; $display("FAIL first_rise_stb: got %b expected 1", rise_stb);
        end
        wait_rise(200, c);
        checks++;
        if (c != 2 * RESET_DIV) begin
            failures++; $display("FAIL default_period: got %0d expected %0d", c, 2 * RESET_DIV);
        end
        rises = 2; cyc = c;
        do begin
            @(negedge clk); cyc++;
            if (rise_stb === 1'b1) rises++;
        end while (sample_stb !== 1'b1 && cyc < 5000);
        checks++;
        if (rises != DECIM) begin
            failures++; $display("FAIL sample_rise_count: got %0d expected %0d", rises, DECIM);
        end
        checks++;
        if (cyc != (DECIM - 1) * 2 * RESET_DIV) begin
            failures++; $display("FAIL sample_delay: got %0d expected %0d", cyc, (DECIM - 1) * 2 * RESET_DIV);
        end
    endtask

    task automatic test_stop();
        int c, t, rises;
        repeat (4) wait_rise(200, c);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        t = 3;
        do begin @(negedge clk); t++; end while (div_clk === 1'b1 && t < 200);
        checks++;
        if (t != RESET_DIV) begin
            failures++; $display("FAIL stop_high_len: got %0d expected %0d", t, RESET_DIV);
        end
        checks++;
        if (running !== 1'b0) begin
            failures++; $display("FAIL stop_running_at_fall: got %b expected 0", running);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({div_clk, running, rise_stb} !== 3'b000) begin
            failures++; $display("FAIL stop_stays_idle: got %b%b%b expected 000", div_clk, running, rise_stb);
        end
        // Four rises preceded the stop; a cleared decimator needs DECIM fresh ones.
        enable = 1'b1;
        rises = 0; t = 0;
        do begin
            @(negedge clk); t++;
            if (rise_stb === 1'b1) rises++;
        end while (sample_stb !== 1'b1 && t < 6000);
        checks++;
        if (rises != DECIM) begin
            failures++; $display("FAIL stop_dec_cleared: got %0d rises expected %0d", rises, DECIM);
        end
    endtask

    task automatic test_reload_mid_high();
        int c, t, hi;
        wait_rise(200, c);
        t = 0;
        do begin
            @(negedge clk); t++;
            if (t == 5) begin div_value = 8'd10; div_load = 1'b1; end
            if (t == 6) div_load = 1'b0;
            if (t == 10) begin
                checks++;
                if (cur_div !== DIV_W'(RESET_DIV)) begin
                    failures++; $display("FAIL reload_early_apply: got %0d expected %0d", cur_div, RESET_DIV);
                end
            end
        end while (rise_stb !== 1'b1 && t < 300);
        checks++;
        if (t != 2 * RESET_DIV) begin
            failures++; $display("FAIL reload_old_period: got %0d expected %0d", t, 2 * RESET_DIV);
        end
        checks++;
        if (cur_div !== 8'd10) begin
            failures++; $display("FAIL reload_cur_div: got %0d expected 10", cur_div);
        end
        t = 0; hi = 0;
        do begin
            @(negedge clk); t++;
            if (div_clk === 1'b1) hi++;
        end while (rise_stb !== 1'b1 && t < 300);
        checks++;
        if (t != 20 || hi != 10) begin
            failures++; $display("FAIL reload_new_period: got period=%0d high=%0d expected 20 10", t, hi);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int exp_len [3] = '{20, 16, 24};
        int exp_div [3] = '{8, 12, 12};
        for (int p = 0; p < 3; p++) begin
            t = 0;
            do begin
                @(negedge clk); t++;
                if (p == 0 && t == 2)  begin div_value = 8'd8; div_load = 1'b1; end
                if (p == 0 && t == 3)  div_load = 1'b0;
                if (p == 0 && t == 19) begin div_value = 8'd12; div_load = 1'b1; end
            end while (rise_stb !== 1'b1 && t < 300);
            div_load = 1'b0;
            checks++;
            if (t != exp_len[p] || int'(cur_div) != exp_div[p]) begin
                failures++;
                $display("FAIL back_to_back_p%0d: got period=%0d cur_div=%0d expected %0d %0d",
                         p, t, cur_div, exp_len[p], exp_div[p]);
            end
        end
    endtask

    task automatic test_load_zero();
        int c;
        enable = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (running === 1'b1 && c < 100);
        checks++;
        if (running !== 1'b0) begin
            failures++; $display("FAIL zero_stop_timeout: got running=%b expected 0", running);
        end
        div_value = '0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        @(negedge clk);
        checks++;
        if (cur_div !== 8'd1) begin
            failures++; $display("FAIL zero_clamp: got %0d expected 1", cur_div);
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({div_clk, rise_stb} !== {2{i[0]}}) begin
                failures++;
                $display("FAIL zero_toggle_%0d: got div_clk=%b rise=%b expected %b %b",
                         i, div_clk, rise_stb, i[0], i[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        div_value = 8'd5; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        wait_rise(50, c);
        wait_rise(50, c);
        checks++;
        if (c != 10 || cur_div !== 8'd5 || div_clk !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_setup: got period=%0d cur_div=%0d div_clk=%b expected 10 5 1", c, cur_div, div_clk);
        end
        #2 resetn = 1'b0; enable = 1'b0;
        #1;
        checks++;
        if ({div_clk, rise_stb, sample_stb, running, cur_div} !== {4'b0000, DIV_W'(RESET_DIV)}) begin
            failures++;
            $display("FAIL mid_reset_async: got clk/rise/sample/run=%b%b%b%b cur_div=%0d expected 0000 %0d",
                     div_clk, rise_stb, sample_stb, running, cur_div, RESET_DIV);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({div_clk, running} !== 2'b00 || cur_div !== DIV_W'(RESET_DIV)) begin
            failures++;
            $display("FAIL mid_reset_release: got div_clk=%b running=%b cur_div=%0d expected 0 0 %0d",
                     div_clk, running, cur_div, RESET_DIV);
        end
    endtask

    task automatic test_random();
        enable = 1'b1; div_value = 8'd3; div_load = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if ({div_clk, rise_stb, sample_stb, running, cur_div} !==
                {m.level, m.rise, m.sample, (m.mode != M_IDLE), DIV_W'(m.h)}) begin
                failures++;
                $display("FAIL random_cycle_%0d: got clk/rise/sample/run=%b%b%b%b cur_div=%0d expected %b%b%b%b %0d",
                         i, div_clk, rise_stb, sample_stb, running, cur_div,
                         m.level, m.rise, m.sample, (m.mode != M_IDLE), m.h);
            end
            if (enable) begin
                if ($urandom_range(0, 999) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                enable = 1'b1;
            end
            div_load  = ($urandom_range(0, 59) == 0);
            div_value = DIV_W'($urandom_range(0, 7));
        end
        div_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_stop();
        test_reload_mid_high();
        test_back_to_back();
        test_load_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
